// File: rtl/conv_mac_accumulate.sv
// Windowed multiply-accumulate: sums TAPS pixel*coeff products per window and emits one sum with a start pulse.
// Optional build macro ACC_SATURATE_EN clamps the final 18-bit sum to 16'hFFFF instead of wrapping modulo 2^16.
module conv_mac_accumulate #(
    parameter int TAPS  = 9,
    parameter int CNT_W = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ValidIn,
    input  logic        FirstIn,
    input  logic [7:0]  PixelIn,
    input  logic [5:0]  CoeffIn,
    output logic        StartOut,
    output logic [15:0] DataOut,
    output logic        Busy,
    output logic        SeqErr
);

    // Handshake: there is no back-pressure; every cycle with ValidIn high offers one tap,
    // which the FSM either accepts into the pipeline or drops (setting SeqErr).
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               seq_err_q, seq_err_d;
    logic               accept, tag_first, tag_last;

    logic               s0_valid_q, s0_first_q, s0_last_q;
    logic [7:0]         s0_pix_q;
    logic [5:0]         s0_coeff_q;
    logic               p1_valid_q, p1_first_q, p1_last_q;
    logic [13:0]        p1_prod_q;
    logic [17:0]        acc_q, acc_d, sum_w;
    logic               start_q, start_d;
    logic [15:0]        data_q, data_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seq_err_d = seq_err_q;
        accept    = 1'b0;
        tag_first = 1'b0;
        tag_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ValidIn && FirstIn) begin
                    accept    = 1'b1;
                    tag_first = 1'b1;
                    cnt_d     = CNT_W'(1);
                    state_d   = ACCUM;
                end else if (ValidIn) begin
                    seq_err_d = 1'b1;
                end
            end
            ACCUM: begin
                if (ValidIn) begin
                    accept = 1'b1;
                    // A restart mid-window overwrites the accumulator, so the partial sum never emerges.
                    if (FirstIn) begin
                        tag_first = 1'b1;
                        seq_err_d = 1'b1;
                        cnt_d     = CNT_W'(1);
                    end else if (cnt_q == LAST_CNT) begin
                        tag_last = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sum_w   = p1_first_q ? 18'(p1_prod_q) : acc_q + 18'(p1_prod_q);
        acc_d   = p1_valid_q ? sum_w : acc_q;
        start_d = p1_valid_q && p1_last_q;
        data_d  = '0;
        if (start_d) begin
`ifdef ACC_SATURATE_EN
            data_d = (sum_w > 18'h0FFFF) ? 16'hFFFF : sum_w[15:0];
`else
            data_d = sum_w[15:0];
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            seq_err_q  <= 1'b0;
            s0_valid_q <= 1'b0;
            s0_first_q <= 1'b0;
            s0_last_q  <= 1'b0;
            s0_pix_q   <= '0;
            s0_coeff_q <= '0;
            p1_valid_q <= 1'b0;
            p1_first_q <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_prod_q  <= '0;
            acc_q      <= '0;
            start_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seq_err_q  <= seq_err_d;
            s0_valid_q <= accept;
            s0_first_q <= tag_first;
            s0_last_q  <= tag_last;
            s0_pix_q   <= PixelIn;
            s0_coeff_q <= CoeffIn;
            p1_valid_q <= s0_valid_q;
            p1_first_q <= s0_first_q;
            p1_last_q  <= s0_last_q;
            p1_prod_q  <= 14'(s0_pix_q) * 14'(s0_coeff_q);
            acc_q      <= acc_d;
            start_q    <= start_d;
            data_q     <= data_d;
        end
    end

    assign StartOut = start_q;
    assign DataOut  = data_q;
    assign Busy     = (state_q == ACCUM);
    assign SeqErr   = seq_err_q;

endmodule

// File: tb/tb_conv_mac_accumulate.sv
// Directed bench for conv_mac_accumulate (TAPS=9); expected sums are hand-computed constants.
module tb_conv_mac_accumulate;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ValidIn = 1'b0;
    logic        FirstIn = 1'b0;
    logic [7:0]  PixelIn = '0;
    logic [5:0]  CoeffIn = '0;
    logic        StartOut;
    logic [15:0] DataOut;
    logic        Busy;
    logic        SeqErr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tap_cyc = 0;
    int last_tap;
    logic [15:0] exp_q[$];
    int pulse_q[$];

    conv_mac_accumulate #(.TAPS(9), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .ValidIn(ValidIn), .FirstIn(FirstIn),
        .PixelIn(PixelIn), .CoeffIn(CoeffIn), .StartOut(StartOut),
        .DataOut(DataOut), .Busy(Busy), .SeqErr(SeqErr)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every pulse consumes one expected sum; DataOut must read 0 between pulses.
    always @(negedge clock) begin
        if (StartOut) begin
            pulse_q.push_back(cyc);
            if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
            else check("data", 32'(DataOut), 32'(exp_q.pop_front()));
        end else begin
            check("data_idle", 32'(DataOut), 0);
        end
    end

    task automatic drive(input logic v, input logic f, input logic [7:0] p, input logic [5:0] c);
        @(negedge clock);
        ValidIn = v;
        FirstIn = f;
        PixelIn = p;
        CoeffIn = c;
        tap_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            ValidIn = 1'b0;
            FirstIn = 1'b0;
        end
    endtask

    task automatic window(input logic [7:0] p, input logic [5:0] c);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, i == 0, p, c);
            if (i == 4) check("busy_mid", 32'(Busy), 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b1;
        ValidIn = 1'b0;
        FirstIn = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        pulse_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_start", 32'(StartOut), 0);
        check("rst_data", 32'(DataOut), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_seqerr", 32'(SeqErr), 0);

        // 9 x 100*7 = 6300, pulse 2 cycles after tap 8
        exp_q.push_back(16'd6300);
        window(8'd100, 6'd7);
        last_tap = tap_cyc;
        idle(6);
        check("w1_pulses", pulse_q.size(), 1);
        if (pulse_q.size() >= 1) check("w1_latency", pulse_q[0] - last_tap, 2);
        check("w1_busy_after", 32'(Busy), 0);
        check("w1_pending", exp_q.size(), 0);
        pulse_q.delete();

        // 9 x 255*63 = 144585
`ifdef ACC_SATURATE_EN
        exp_q.push_back(16'hFFFF);
`else
        exp_q.push_back(16'd13513);
`endif
        window(8'd255, 6'd63);
        idle(6);
        check("w2_pulses", pulse_q.size(), 1);
        check("w2_pending", exp_q.size(), 0);
        pulse_q.delete();

        // back-to-back windows, 9 x 10*7 = 630 each
        exp_q.push_back(16'd630);
        exp_q.push_back(16'd630);
        window(8'd10, 6'd7);
        window(8'd10, 6'd7);
        idle(6);
        check("b2b_pulses", pulse_q.size(), 2);
        if (pulse_q.size() >= 2) check("b2b_spacing", pulse_q[1] - pulse_q[0], 9);
        check("b2b_seqerr", 32'(SeqErr), 0);
        check("b2b_pending", exp_q.size(), 0);
        pulse_q.delete();

        // restart at tap 4, then 9 x 1*7 = 63
        exp_q.push_back(16'd63);
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 8'd5, 6'd7);
        window(8'd1, 6'd7);
        idle(6);
        check("rs_pulses", pulse_q.size(), 1);
        check("rs_seqerr", 32'(SeqErr), 1);
        check("rs_pending", exp_q.size(), 0);

        // orphan tap from IDLE is dropped
        do_reset();
        check("or_seqerr_clr", 32'(SeqErr), 0);
        drive(1'b1, 1'b0, 8'd100, 6'd7);
        idle(5);
        check("or_seqerr", 32'(SeqErr), 1);
        check("or_busy", 32'(Busy), 0);
        check("or_pulses", pulse_q.size(), 0);
        exp_q.push_back(16'd6300);
        window(8'd100, 6'd7);
        idle(6);
        check("or_next_pulses", pulse_q.size(), 1);
        check("or_pending", exp_q.size(), 0);

        // reset at tap 5 discards the window
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 8'd50, 6'd7);
        @(negedge clock);
        reset   = 1'b1;
        ValidIn = 1'b1;
        FirstIn = 1'b0;
        @(negedge clock);
        reset   = 1'b0;
        ValidIn = 1'b0;
        check("mr_busy", 32'(Busy), 0);
        check("mr_start", 32'(StartOut), 0);
        idle(5);
        check("mr_pulses", pulse_q.size(), 0);
        exp_q.push_back(16'd63);
        window(8'd1, 6'd7);
        idle(6);
        check("mr_next_pulses", pulse_q.size(), 1);
        check("mr_seqerr", 32'(SeqErr), 0);
        check("mr_pending", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
